// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the set-associative cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    WTHRU,
    RESPOND
  } state_t;

  function automatic int idx_w(input int total_size, input int ways);
    return $clog2(total_size / ways);
  endfunction

  function automatic int tag_w(input int ram_depth, input int total_size, input int ways);
    return $clog2(ram_depth) - idx_w(total_size, ways);
  endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Per-set age tracking for LRU replacement; age 0 is most recent, WAYS-1 is the victim.
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int IW   = 2,
  localparam int WW   = $clog2(WAYS),
  localparam int SETS = 1 << IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch,
  input  logic [IW-1:0] touch_idx,
  input  logic [WW-1:0] touch_way,
  input  logic [IW-1:0] victim_idx,
  output logic [WW-1:0] lru_way
);

  logic [WW-1:0] ages [SETS][WAYS];
  logic [WW-1:0] old_age;

  assign old_age = ages[touch_idx][touch_way];

  // Ages younger than the touched way slide up by one, so each set stays a permutation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ages[s][w] <= WW'(w);
        end
      end
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == touch_way) begin
          ages[touch_idx][w] <= '0;
        end else if (ages[touch_idx][w] < old_age) begin
          ages[touch_idx][w] <= ages[touch_idx][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[victim_idx][w] == WW'(WAYS - 1)) begin
        lru_way = WW'(w);
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative cache controller with write-back/refill miss path to a req/ack RAM.
module cache_ctrl_assoc
  import cache_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int RAM_DEPTH  = 256,
  parameter int WRITE_BACK = 1,
  parameter int CNT_W      = 16,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int  IW   = idx_w(TOTAL_SIZE, WAYS);
  localparam int  TW   = tag_w(RAM_DEPTH, TOTAL_SIZE, WAYS);
  localparam int  WW   = $clog2(WAYS);
  localparam int  SETS = TOTAL_SIZE / WAYS;
  localparam bit  WB   = (WRITE_BACK != 0);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TW-1:0]    tag;
    logic [WIDTH-1:0] data;
  } line_t;

  state_t           state;
  line_t            lines [SETS][WAYS];
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WW-1:0]    victim_r;

  logic [IW-1:0]    cur_idx;
  logic [TW-1:0]    cur_tag;
  logic             hit;
  logic [WW-1:0]    hit_way;
  logic             has_inv;
  logic [WW-1:0]    inv_way;
  logic [WW-1:0]    lru_way;
  logic [WW-1:0]    victim_way;
  line_t            victim_line;
  line_t            hit_line;
  logic             mem_done;
  logic             touch;
  logic [WW-1:0]    touch_way;

  assign cur_idx   = r_addr[IW-1:0];
  assign cur_tag   = r_addr[AW-1:IW];
  assign req_ready = (state == IDLE);
  assign mem_done  = mem_req && mem_ack;

  // Scanning downward lets the lowest matching or invalid way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lines[cur_idx][w].valid && (lines[cur_idx][w].tag == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!lines[cur_idx][w].valid) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign victim_way  = has_inv ? inv_way : lru_way;
  assign victim_line = lines[cur_idx][victim_way];
  assign hit_line    = lines[cur_idx][hit_way];

  assign touch     = ((state == LOOKUP) && hit) || ((state == REFILL) && mem_done);
  assign touch_way = (state == LOOKUP) ? hit_way : victim_r;

  cache_lru_ages #(
    .WAYS (WAYS),
    .IW   (IW)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .touch      (touch),
    .touch_idx  (cur_idx),
    .touch_way  (touch_way),
    .victim_idx (cur_idx),
    .lru_way    (lru_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      victim_r   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lines[s][w] <= '0;
        end
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            state   <= LOOKUP;
          end
        end

        LOOKUP: begin
          victim_r <= victim_way;
          resp_hit <= hit;
          if (hit) begin
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            if (r_we) begin
              lines[cur_idx][hit_way].data <= r_wdata;
              if (WB) begin
                lines[cur_idx][hit_way].dirty <= 1'b1;
                resp_rdata <= '0;
                resp_valid <= 1'b1;
                state      <= RESPOND;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= r_addr;
                mem_wdata <= r_wdata;
                state     <= WTHRU;
              end
            end else begin
              resp_rdata <= hit_line.data;
              resp_valid <= 1'b1;
              state      <= RESPOND;
            end
          end else begin
            if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
            if (r_we && !WB) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= r_addr;
              mem_wdata <= r_wdata;
              state     <= WTHRU;
            end else if (WB && victim_line.valid && victim_line.dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {victim_line.tag, cur_idx};
              mem_wdata <= victim_line.data;
              state     <= WRITEBACK;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= r_addr;
              mem_wdata <= '0;
              state     <= REFILL;
            end
          end
        end

        // mem_req stays high so the refill read follows the victim write directly.
        WRITEBACK: begin
          if (mem_done) begin
            mem_we    <= 1'b0;
            mem_addr  <= r_addr;
            mem_wdata <= '0;
            state     <= REFILL;
          end
        end

        REFILL: begin
          if (mem_done) begin
            mem_req                   <= 1'b0;
            lines[cur_idx][victim_r]  <= '{valid: 1'b1,
                                           dirty: r_we,
                                           tag:   cur_tag,
                                           data:  r_we ? r_wdata : mem_rdata};
            resp_rdata                <= r_we ? '0 : mem_rdata;
            resp_valid                <= 1'b1;
            state                     <= RESPOND;
          end
        end

        WTHRU: begin
          if (mem_done) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESPOND;
          end
        end

        RESPOND: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench: instance 0 is write-back, instance 1 write-through, each with its own RAM model.
module tb_cache_ctrl_assoc;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic       req_we     [2];
  logic [7:0] req_addr   [2];
  logic [7:0] req_wdata  [2];
  logic       resp_valid [2];
  logic [7:0] resp_rdata [2];
  logic       resp_hit   [2];
  logic [15:0] hit_count  [2];
  logic [15:0] miss_count [2];

  int   ack_delay = 3;
  logic ack_hold  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack   = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic [7:0] ram [256];
    logic [255:0] written = '0;
    int   cnt = 0, rd_cnt = 0, wr_cnt = 0, req_cycles = 0;
    logic last_we = 1'b0, prev_we = 1'b0;
    logic [7:0] last_addr = '0, prev_addr = '0, last_wdata = '0, prev_wdata = '0;

    cache_ctrl_assoc #(
      .WIDTH(8), .WAYS(4), .TOTAL_SIZE(16), .RAM_DEPTH(256),
      .WRITE_BACK((g == 0) ? 1 : 0), .CNT_W(16)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]), .resp_hit(resp_hit[g]),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count[g]), .miss_count(miss_count[g])
    );

    // Unwritten RAM words read back as addr ^ 0xA0.
    always @(posedge clk) begin
      mem_ack <= 1'b0;
      if (mem_req) req_cycles <= req_cycles + 1;
      if (!mem_req || mem_ack) begin
        cnt <= 0;
      end else if (!ack_hold) begin
        if (cnt >= ack_delay - 1) begin
          mem_ack    <= 1'b1;
          mem_rdata  <= written[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'hA0);
          prev_we    <= last_we;
          prev_addr  <= last_addr;
          prev_wdata <= last_wdata;
          last_we    <= mem_we;
          last_addr  <= mem_addr;
          last_wdata <= mem_wdata;
          if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
            wr_cnt            <= wr_cnt + 1;
          end else begin
            rd_cnt <= rd_cnt + 1;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request, waits for its response pulse; lat counts edges from accept.
  task automatic applyStimulus(input int g, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, output logic [7:0] rdata,
                               output logic hit, output int lat);
    int n;
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_we[g]    = we;
    req_addr[g]  = addr;
    req_wdata[g] = wdata;
    n = 0;
    while (!req_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    lat = 1;
    while (!resp_valid[g] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("resp_seen", 32'(resp_valid[g]), 32'd1);
    rdata = resp_rdata[g];
    hit   = resp_hit[g];
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       ht;
    int         lat, b0, b1, n, pulses;
    logic       ok;

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_we[g]    = 1'b0;
      req_addr[g]  = '0;
      req_wdata[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset checks");
    checkOutput("rst_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    checkOutput("rst_mem_req", 32'(g_dut[0].mem_req), 32'd0);
    checkOutput("rst_hits", 32'(hit_count[0]), 32'd0);
    checkOutput("rst_misses", 32'(miss_count[1]), 32'd0);

    $display("[TB] cold read then hit");
    b0 = g_dut[0].rd_cnt;
    applyStimulus(0, 1'b0, 8'h05, 8'h00, rd, ht, lat);
    checkOutput("cold_rdata", 32'(rd), 32'hA5);
    checkOutput("cold_hit", 32'(ht), 32'd0);
    checkOutput("cold_misses", 32'(miss_count[0]), 32'd1);
    checkOutput("cold_mem_reads", 32'(g_dut[0].rd_cnt - b0), 32'd1);
    checkOutput("cold_mem_addr", 32'(g_dut[0].last_addr), 32'h05);
    b0 = g_dut[0].req_cycles;
    applyStimulus(0, 1'b0, 8'h05, 8'h00, rd, ht, lat);
    checkOutput("rehit_hit", 32'(ht), 32'd1);
    checkOutput("rehit_rdata", 32'(rd), 32'hA5);
    checkOutput("rehit_latency", 32'(lat), 32'd2);
    checkOutput("rehit_no_mem", 32'(g_dut[0].req_cycles - b0), 32'd0);
    checkOutput("rehit_hits", 32'(hit_count[0]), 32'd1);

    $display("[TB] LRU replacement in set 0");
    applyStimulus(0, 1'b0, 8'h00, 8'h00, rd, ht, lat);
    applyStimulus(0, 1'b0, 8'h04, 8'h00, rd, ht, lat);
    applyStimulus(0, 1'b0, 8'h08, 8'h00, rd, ht, lat);
    applyStimulus(0, 1'b0, 8'h0C, 8'h00, rd, ht, lat);
    checkOutput("fill_0C_rdata", 32'(rd), 32'hAC);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, rd, ht, lat);
    checkOutput("reread_00_hit", 32'(ht), 32'd1);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, rd, ht, lat);
    checkOutput("read_10_hit", 32'(ht), 32'd0);
    checkOutput("read_10_rdata", 32'(rd), 32'hB0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, rd, ht, lat);
    checkOutput("keep_00_hit", 32'(ht), 32'd1);
    checkOutput("keep_00_rdata", 32'(rd), 32'hA0);
    applyStimulus(0, 1'b0, 8'h04, 8'h00, rd, ht, lat);
    checkOutput("evicted_04_hit", 32'(ht), 32'd0);
    checkOutput("evicted_04_rdata", 32'(rd), 32'hA4);
    checkOutput("lru_hits", 32'(hit_count[0]), 32'd3);
    checkOutput("lru_misses", 32'(miss_count[0]), 32'd7);

    $display("[TB] write-back of dirty victim");
    b0 = g_dut[0].wr_cnt;
    applyStimulus(0, 1'b1, 8'h05, 8'h5A, rd, ht, lat);
    checkOutput("wb_write_hit", 32'(ht), 32'd1);
    checkOutput("wb_write_rdata", 32'(rd), 32'h00);
    checkOutput("wb_no_early_write", 32'(g_dut[0].wr_cnt - b0), 32'd0);
    applyStimulus(0, 1'b0, 8'h01, 8'h00, rd, ht, lat);
    applyStimulus(0, 1'b0, 8'h09, 8'h00, rd, ht, lat);
    applyStimulus(0, 1'b0, 8'h0D, 8'h00, rd, ht, lat);
    checkOutput("wb_fill_0D_hit", 32'(ht), 32'd0);
    applyStimulus(0, 1'b0, 8'h11, 8'h00, rd, ht, lat);
    checkOutput("wb_read_11_rdata", 32'(rd), 32'hB1);
    checkOutput("wb_write_count", 32'(g_dut[0].wr_cnt - b0), 32'd1);
    checkOutput("wb_prev_we", 32'(g_dut[0].prev_we), 32'd1);
    checkOutput("wb_prev_addr", 32'(g_dut[0].prev_addr), 32'h05);
    checkOutput("wb_prev_wdata", 32'(g_dut[0].prev_wdata), 32'h5A);
    checkOutput("wb_last_we", 32'(g_dut[0].last_we), 32'd0);
    checkOutput("wb_last_addr", 32'(g_dut[0].last_addr), 32'h11);
    checkOutput("wb_misses", 32'(miss_count[0]), 32'd11);

    $display("[TB] write-through instance");
    applyStimulus(1, 1'b0, 8'h05, 8'h00, rd, ht, lat);
    checkOutput("wt_cold_rdata", 32'(rd), 32'hA5);
    b1 = g_dut[1].wr_cnt;
    applyStimulus(1, 1'b1, 8'h05, 8'h3C, rd, ht, lat);
    checkOutput("wt_write_hit", 32'(ht), 32'd1);
    checkOutput("wt_write_count", 32'(g_dut[1].wr_cnt - b1), 32'd1);
    checkOutput("wt_write_addr", 32'(g_dut[1].last_addr), 32'h05);
    checkOutput("wt_write_data", 32'(g_dut[1].last_wdata), 32'h3C);
    applyStimulus(1, 1'b0, 8'h05, 8'h00, rd, ht, lat);
    checkOutput("wt_reread_hit", 32'(ht), 32'd1);
    checkOutput("wt_reread_rdata", 32'(rd), 32'h3C);
    b0 = g_dut[1].rd_cnt;
    applyStimulus(1, 1'b1, 8'h21, 8'h77, rd, ht, lat);
    checkOutput("wt_wmiss_hit", 32'(ht), 32'd0);
    checkOutput("wt_wmiss_no_refill", 32'(g_dut[1].rd_cnt - b0), 32'd0);
    checkOutput("wt_wmiss_addr", 32'(g_dut[1].last_addr), 32'h21);
    applyStimulus(1, 1'b0, 8'h21, 8'h00, rd, ht, lat);
    checkOutput("wt_read_21_hit", 32'(ht), 32'd0);
    checkOutput("wt_read_21_rdata", 32'(rd), 32'h77);
    checkOutput("wt_hits", 32'(hit_count[1]), 32'd2);
    checkOutput("wt_misses", 32'(miss_count[1]), 32'd3);

    $display("[TB] reset during refill");
    ack_delay = 50;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 8'h30;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!(g_dut[0].mem_req && !g_dut[0].mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_refill_req", 32'(g_dut[0].mem_req), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_mem_req", 32'(g_dut[0].mem_req), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready[0]), 32'd1);
    rst = 1'b0;
    checkOutput("mid_rst_hits", 32'(hit_count[0]), 32'd0);
    checkOutput("mid_rst_misses", 32'(miss_count[0]), 32'd0);
    pulses = 0;
    repeat (10) begin
      if (resp_valid[0]) pulses++;
      @(negedge clk);
    end
    checkOutput("mid_rst_no_resp", 32'(pulses), 32'd0);
    ack_delay = 3;
    applyStimulus(0, 1'b0, 8'h05, 8'h00, rd, ht, lat);
    checkOutput("post_rst_hit", 32'(ht), 32'd0);
    checkOutput("post_rst_rdata", 32'(rd), 32'h5A);
    checkOutput("post_rst_misses", 32'(miss_count[0]), 32'd1);

    $display("[TB] long ack stall");
    ack_hold = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 8'h40;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!g_dut[0].mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = 1'b1;
    repeat (20) begin
      if (!(g_dut[0].mem_req === 1'b1 && g_dut[0].mem_addr === 8'h40 &&
            req_ready[0] === 1'b0 && resp_valid[0] === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_stable", 32'(ok), 32'd1);
    ack_hold = 1'b0;
    pulses = 0;
    rd = '0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid[0]) begin
        pulses++;
        rd = resp_rdata[0];
      end
    end
    checkOutput("stall_one_resp", 32'(pulses), 32'd1);
    checkOutput("stall_rdata", 32'(rd), 32'hE0);
    checkOutput("stall_mem_released", 32'(g_dut[0].mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
